banco_registros_issue: RTL
==========================

Name: banco_registros_issue

Overview:
Register-bank issue stage sitting directly upstream of the ALU. Holds the 32-entry architectural register file, accepts decoded instructions (rs1, rs2, rd, op), reads both operands and presents them with the opcode in a registered output stage that drives the ALU operand and OP inputs. The ALU result returns through the write-back port and is written into the bank.

Parameters:
DATA_W, 32, register and operand width; matches the ALU result width.
ADDR_W, 5, register index width; the bank has 2**ADDR_W entries.
OP_W, 4, opcode width passed through to the ALU.

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  decoded instruction present.
in_ready  out  1  stage can accept this cycle.
in_rs1  in  ADDR_W  source register index for operand A.
in_rs2  in  ADDR_W  source register index for operand B.
in_rd  in  ADDR_W  destination index, carried to write-back.
in_op  in  OP_W  ALU opcode.
out_valid  out  1  operands valid toward the ALU.
out_ready  in  1  ALU/downstream consumes this cycle.
out_a  out  DATA_W  operand A.
out_b  out  DATA_W  operand B.
out_op  out  OP_W  registered opcode.
out_rd  out  ADDR_W  registered destination index.
wb_en  in  1  write-back strobe.
wb_rd  in  ADDR_W  write-back index.
wb_data  in  DATA_W  write-back data (ALU result).

Behaviour:
- Reset (rst_n low, asynchronous): all bank entries = 0; out_valid = 0; out_a, out_b, out_op, out_rd = 0. Any in-flight instruction is discarded. Deassertion is synchronised externally.
- in_ready = !out_valid || out_ready (combinational). Transfer-in occurs when in_valid && in_ready.
- Output stage has two states, EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - EMPTY + accept → FULL.
  - FULL + out_ready without accept → EMPTY.
  - FULL + out_ready with accept → stays FULL with new contents.
  - FULL + !out_ready → holds all outputs stable.
- Latency: 1 cycle from accept edge to out_valid. Throughput: 1 instruction per cycle while out_ready is high.
- Operand capture happens at the accept edge: out_a = R[in_rs1], out_b = R[in_rs2], out_op = in_op, out_rd = in_rd.
- Register 0 always reads 0, and writes to it are ignored (including the bypass path).
- Write-back: on a rising edge with wb_en = 1 and wb_rd != 0, R[wb_rd] <= wb_data. Write-back is independent of both handshakes and is never stalled.
- Operands held in FULL are not refreshed by later write-backs; the scheduler owns RAW hazards beyond the same-cycle case.
- Both sources equal: both operands receive the same value, with bypass applied to each independently.
- Reset during a stall: out_valid drops immediately; no ALU transfer completes.

Optional Feature:
Macro REGFILE_BYPASS_EN controls same-cycle write-back forwarding.
- Defined: when the accept edge coincides with wb_en = 1 and wb_rd == rsX != 0, the captured operand is wb_data (write-first).
- Undefined: the captured operand is the pre-write bank value (read-first). The new value is visible from the next accept onward.

Decomposition:
- Shared package: DATA_W, ADDR_W, OP_W defaults, and the ALU opcode constants (ADD = 4'b0000, SUB = 4'b0001, AND = 4'b0010, MUL = 4'b0011), so decode, this stage and the ALU share one opcode definition.
- One sub-module: regfile_2r1w (2 combinational read ports, 1 synchronous write port, x0 hardwired to zero, async active-low reset). The bypass mux and the output stage stay in the top.

Test Plan:
- Reset then idle → out_valid = 0, in_ready = 1, out_a = out_b = 0; reads of every index return 0.
- Write R5 = 0x0000_0007 and R6 = 0x0000_0003, then issue rs1 = 5, rs2 = 6, rd = 7, op = 0001 → one cycle later out_valid = 1, out_a = 7, out_b = 3, out_op = 0001, out_rd = 7.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0 and outputs stable; on the cycle out_ready rises the next instruction is accepted with no bubble.
- wb_en = 1, wb_rd = 0, wb_data = 0xFFFF_FFFF, then issue rs1 = 0 → out_a = 0.
- Same edge: wb_rd = 9, wb_data = 0x1234, accept rs1 = 9 (old R9 = 0x55) → out_a = 0x1234 with REGFILE_BYPASS_EN, 0x55 without.
- Assert rst_n = 0 mid-cycle while FULL and stalled → out_valid falls without a clock edge; R9 reads 0 after release.

Source files
------------

// File: rtl/banco_registros_issue_pkg.sv
// ----------------------------------------------------------------------------
// banco_registros_issue_pkg
// Shared definitions for decode, the register-bank issue stage and the ALU:
// default widths and the ALU opcode encoding.
// ----------------------------------------------------------------------------
package banco_registros_issue_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_OP_W   = 4;

   localparam logic [DEF_OP_W-1:0] OP_ADD = 4'b0000;
   localparam logic [DEF_OP_W-1:0] OP_SUB = 4'b0001;
   localparam logic [DEF_OP_W-1:0] OP_AND = 4'b0010;
   localparam logic [DEF_OP_W-1:0] OP_MUL = 4'b0011;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } issue_state_e;

endpackage : banco_registros_issue_pkg

// File: rtl/banco_registros_issue_regfile_2r1w.sv
// ----------------------------------------------------------------------------
// banco_registros_issue_regfile_2r1w
// Architectural register file: 2 combinational read ports, 1 synchronous
// write port. Entry 0 is hardwired to zero (writes to it are dropped).
// Ports:
//   clk, rst_n            clock, async active-low reset (clears all entries)
//   raddr_a_i/rdata_a_o   read port A
//   raddr_b_i/rdata_b_o   read port B
//   we_i, waddr_i, wdata_i write port
// ----------------------------------------------------------------------------
module banco_registros_issue_regfile_2r1w
   import banco_registros_issue_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] raddr_a_i,
   output logic [DATA_W-1:0] rdata_a_o,
   input  logic [ADDR_W-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_b_o,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
   assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule : banco_registros_issue_regfile_2r1w

// File: rtl/banco_registros_issue.sv
// ----------------------------------------------------------------------------
// banco_registros_issue
// Register-bank issue stage feeding the ALU. Reads both source operands of a
// decoded instruction and presents them, with opcode and destination, in a
// registered valid/ready output stage. ALU results return via the write-back
// port, which is never stalled.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready, in_rs1/in_rs2/in_rd/in_op   decoded instruction input
//   out_valid/out_ready, out_a/out_b/out_op/out_rd operand output to the ALU
//   wb_en, wb_rd, wb_data           write-back from the ALU
// Build option:
//   REGFILE_BYPASS_EN  defined: write-back on the accept edge is forwarded
//                      into the captured operand (write-first).
//                      undefined: the pre-write bank value is captured.
//
// state    | meaning
// ST_EMPTY | no operands held, out_valid = 0
// ST_FULL  | operands held for the ALU, out_valid = 1
// ----------------------------------------------------------------------------
module banco_registros_issue
   import banco_registros_issue_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int OP_W   = DEF_OP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [OP_W-1:0]   in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [OP_W-1:0]   out_op,
   output logic [ADDR_W-1:0] out_rd,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data
);

   issue_state_e      state_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic [OP_W-1:0]   op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] rdata_a, rdata_b;
   logic [DATA_W-1:0] a_d, b_d;
   logic              accept;

   banco_registros_issue_regfile_2r1w #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .raddr_a_i (in_rs1),
      .rdata_a_o (rdata_a),
      .raddr_b_i (in_rs2),
      .rdata_b_o (rdata_b),
      .we_i      (wb_en),
      .waddr_i   (wb_rd),
      .wdata_i   (wb_data)
   );

`ifdef REGFILE_BYPASS_EN
   // x0 is excluded so a write-back aimed at x0 can never leak into an operand.
   assign a_d = (wb_en && (wb_rd != '0) && (wb_rd == in_rs1)) ? wb_data : rdata_a;
   assign b_d = (wb_en && (wb_rd != '0) && (wb_rd == in_rs2)) ? wb_data : rdata_b;
`else
   assign a_d = rdata_a;
   assign b_d = rdata_b;
`endif

   assign out_valid = (state_q == ST_FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         rd_q    <= '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_q <= ST_FULL;
                  a_q     <= a_d;
                  b_q     <= b_d;
                  op_q    <= in_op;
                  rd_q    <= in_rd;
               end
            end
            ST_FULL: begin
               // accept here implies out_ready, so this is a back-to-back reload
               if (accept) begin
                  a_q  <= a_d;
                  b_q  <= b_d;
                  op_q <= in_op;
                  rd_q <= in_rd;
               end else if (out_ready) begin
                  state_q <= ST_EMPTY;
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   assign out_a  = a_q;
   assign out_b  = b_q;
   assign out_op = op_q;
   assign out_rd = rd_q;

endmodule : banco_registros_issue
